controle_quadrado: RTL and testbench
====================================

# controle_quadrado

Frame-synchronous controller for the colored-square VGA overlay. It samples the size and color switches once per frame at the start of vertical sync, so the square never tears mid-frame. It steps the square's position by a fixed amount each frame, reversing direction at the screen edges. Its outputs drive the position, size and color inputs of the square-drawing datapath, which compares `x`/`y` against `pos_x`/`pos_y` and `pos + tamanho`.

## Interface
- `H_ATIVO`, 640: active horizontal pixels.
- `V_ATIVO`, 480: active vertical lines.
- `PASSO`, 2: pixels moved per frame on each axis; must be at least 1 and below 4.
- `clk`  in  1  pixel clock; sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  VGA vertical sync from the sync generator, active-low, same clock domain.
- `pausa`  in  1  level; while sampled high at frame start, motion is frozen.
- `sw_tamanhos`  in  6  size code.
- `sw_cor`  in  4  color code, passed to the color decoder.
- `pos_x`  out  10  square left edge.
- `pos_y`  out  10  square top edge.
- `tamanho`  out  10  square side length.
- `cor`  out  4  latched color code.
- `frame_tick`  out  1  one-cycle pulse per frame start.

## Operation
- Registered copy `vsync_q` (reset value 1). A frame start is `vsync_q==1 && vsync==0`.
- `frame_tick` is registered: it is high for the cycle after the frame start is detected. It pulses on every frame start, whatever the FSM state.
- Direction flags: `dir_x` and `dir_y`. 0 means increasing, 1 means decreasing. Reset value 0.
- FSM states: ESPERA → CARREGA → MOVE_X → MOVE_Y → ESPERA. Each state lasts exactly one cycle except ESPERA.
  - A frame start leaves ESPERA.
  - A frame start seen outside ESPERA is ignored by the FSM.
- CARREGA:
  - `tamanho <= 4*sw_tamanhos + 4`, giving a range of 4..256.
  - `cor <= sw_cor`.
  - Clamp: if `pos_x + new tamanho > H_ATIVO`, then `pos_x <= H_ATIVO - new tamanho`. Same rule for `pos_y` against `V_ATIVO`.
  - If `pausa==1`, next state is ESPERA and both MOVE states are skipped.
- MOVE_X, using 11-bit intermediate arithmetic so nothing overflows:
  - `dir_x==0`: if `pos_x + tamanho + PASSO >= H_ATIVO`, then `pos_x <= H_ATIVO - tamanho` and `dir_x <= 1`. Otherwise `pos_x <= pos_x + PASSO`.
  - `dir_x==1`: if `pos_x <= PASSO`, then `pos_x <= 0` and `dir_x <= 0`. Otherwise `pos_x <= pos_x - PASSO`.
- MOVE_Y: identical to MOVE_X, using `pos_y`, `dir_y` and `V_ATIVO`.
- Reset values: `pos_x=0`, `pos_y=0`, `tamanho=4`, `cor=0`, `frame_tick=0`, state ESPERA.
- Reset is asynchronous. Asserting it mid-sequence (any state) forces the reset values immediately. The first frame start after release begins a normal sequence.

## Timing
- Cycle 0: `vsync` is first sampled low while `vsync_q==1`.
- Cycle 1: `frame_tick=1` and the FSM is in CARREGA.
- Cycle 2: new `tamanho` and `cor` are visible, plus any clamped position. FSM is in MOVE_X.
- Cycle 3: new `pos_x` is visible.
- Cycle 4: new `pos_y` is visible and the FSM is back in ESPERA.
- All outputs are stable from cycle 4 until the next frame start, which falls inside vertical blanking.
- `pausa`, `sw_tamanhos` and `sw_cor` are sampled only in CARREGA. Changes at any other time have no effect until the next frame.

## Configuration
- `REBATE_EN` defined: edge behaviour is the bounce described in Operation, with direction flags active.
- `REBATE_EN` undefined: the direction flags are constant 0 and motion wraps around.
  - MOVE_X: if `pos_x + tamanho + PASSO > H_ATIVO`, then `pos_x <= 0`. Otherwise `pos_x <= pos_x + PASSO`.
  - MOVE_Y: same rule, using `pos_y` and `V_ATIVO`.
  - Clamping in CARREGA is unchanged.

## Test plan
- Reset: assert `reset` with `vsync` toggling → `pos_x=0`, `pos_y=0`, `tamanho=4`, `cor=0`, `frame_tick=0` throughout.
- Latch: `sw_tamanhos=24`, `sw_cor=4'hA`, then one `vsync` falling edge.
  - Required: `tamanho=100` and `cor=A` at cycle 2.
  - Changing switches mid-frame leaves both outputs unchanged until the next edge.
- Motion: from reset with size 100, `pausa=0`, 10 frames → `pos_x=20`, `pos_y=20`, with the Timing-section cycle latencies.
- Bounce (`REBATE_EN`): `pos_x=538`, `tamanho=100`, `dir_x=0`.
  - Next frame: `pos_x=540` and `dir_x=1`.
  - Following frame: `pos_x=538`.
- Wrap (no `REBATE_EN`): same setup → next frame `pos_x=540`, then `pos_x=0`.
- Pause and clamp: `pos_y=300`, `pausa=1`, `sw_tamanhos=63`, over 3 frames.
  - Required: `tamanho=256` and `pos_y=224` after the first frame, then constant.
  - Asserting `reset` during MOVE_X returns all outputs to their reset values in the same cycle.

Source files
------------

// File: rtl/controle_quadrado.sv
// controle_quadrado: frame-synchronous position/size/color controller for the VGA square overlay.
// Build macro REBATE_EN: defined -> square bounces at screen edges; undefined -> square wraps to 0.
module controle_quadrado #(
  parameter int H_ATIVO = 640,
  parameter int V_ATIVO = 480,
  parameter int PASSO   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pausa,
  input  logic [5:0] sw_tamanhos,
  input  logic [3:0] sw_cor,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [9:0] tamanho,
  output logic [3:0] cor,
  output logic       frame_tick
);

  // state   | meaning
  // ESPERA  | idle, waiting for vsync falling edge
  // CARREGA | latch size/color switches, clamp position to the new size
  // MOVE_X  | step horizontal position
  // MOVE_Y  | step vertical position
  typedef enum logic [1:0] {ESPERA, CARREGA, MOVE_X, MOVE_Y} estado_t;

  localparam logic [10:0] H_LIM = 11'(H_ATIVO);
  localparam logic [10:0] V_LIM = 11'(V_ATIVO);
  localparam logic [10:0] STEP  = 11'(PASSO);

  estado_t    estado_q, estado_d;
  logic       vsync_q;
  logic       frame_tick_q;
  logic       inicio;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [9:0] tamanho_q, tamanho_d;
  logic [3:0] cor_q, cor_d;
  logic [9:0] tam_novo;

  assign inicio = vsync_q & ~vsync;

`ifdef REBATE_EN
  logic dir_x_q, dir_x_d;
  logic dir_y_q, dir_y_d;

  // Returns {new_dir, new_pos}; 11-bit sums so pos + tam + step cannot overflow.
  function automatic logic [10:0] mover(input logic [9:0] pos, input logic dir,
                                        input logic [9:0] tam, input logic [10:0] lim);
    logic [10:0] pos_ext;
    logic [10:0] soma;
    logic [10:0] res;
    pos_ext = {1'b0, pos};
    soma    = pos_ext + {1'b0, tam} + STEP;
    if (!dir) begin
      if (soma >= lim) res = {1'b1, 10'(lim - {1'b0, tam})};
      else             res = {1'b0, 10'(pos_ext + STEP)};
    end else begin
      if (pos_ext <= STEP) res = {1'b0, 10'd0};
      else                 res = {1'b1, 10'(pos_ext - STEP)};
    end
    return res;
  endfunction
`else
  function automatic logic [9:0] mover(input logic [9:0] pos, input logic [9:0] tam,
                                       input logic [10:0] lim);
    logic [10:0] pos_ext;
    logic [10:0] soma;
    pos_ext = {1'b0, pos};
    soma    = pos_ext + {1'b0, tam} + STEP;
    if (soma > lim) return 10'd0;
    return 10'(pos_ext + STEP);
  endfunction
`endif

  always_comb begin
    estado_d  = estado_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    tamanho_d = tamanho_q;
    cor_d     = cor_q;
`ifdef REBATE_EN
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
`endif
    // 4*code + 4 spans 4..256
    tam_novo  = 10'({sw_tamanhos, 2'b00}) + 10'd4;

    unique case (estado_q)
      ESPERA: begin
        if (inicio) estado_d = CARREGA;
      end
      CARREGA: begin
        tamanho_d = tam_novo;
        cor_d     = sw_cor;
        if (({1'b0, pos_x_q} + {1'b0, tam_novo}) > H_LIM)
          pos_x_d = 10'(H_LIM - {1'b0, tam_novo});
        if (({1'b0, pos_y_q} + {1'b0, tam_novo}) > V_LIM)
          pos_y_d = 10'(V_LIM - {1'b0, tam_novo});
        estado_d = pausa ? ESPERA : MOVE_X;
      end
      MOVE_X: begin
`ifdef REBATE_EN
        {dir_x_d, pos_x_d} = mover(pos_x_q, dir_x_q, tamanho_q, H_LIM);
`else
        pos_x_d = mover(pos_x_q, tamanho_q, H_LIM);
`endif
        estado_d = MOVE_Y;
      end
      MOVE_Y: begin
`ifdef REBATE_EN
        {dir_y_d, pos_y_d} = mover(pos_y_q, dir_y_q, tamanho_q, V_LIM);
`else
        pos_y_d = mover(pos_y_q, tamanho_q, V_LIM);
`endif
        estado_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= ESPERA;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      pos_x_q      <= 10'd0;
      pos_y_q      <= 10'd0;
      tamanho_q    <= 10'd4;
      cor_q        <= 4'd0;
`ifdef REBATE_EN
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      vsync_q      <= vsync;
      frame_tick_q <= inicio;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      tamanho_q    <= tamanho_d;
      cor_q        <= cor_d;
`ifdef REBATE_EN
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
`endif
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign tamanho    = tamanho_q;
  assign cor        = cor_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_controle_quadrado.sv
// Testbench for controle_quadrado: table vectors, directed corner sequences and random frames
// checked against a per-frame behavioural model of the square's motion.
module tb_controle_quadrado;
  localparam int H = 640;
  localparam int V = 480;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       pausa;
  logic [5:0] sw_tamanhos;
  logic [3:0] sw_cor;
  logic [9:0] pos_x, pos_y, tamanho;
  logic [3:0] cor;
  logic       frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  // model state: position, size, color, direction (0 = increasing)
  int mx, my, mt, mc, dx, dy;

  typedef struct {
    int st;
    int sc;
    int exp_tam;
    int exp_cor;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  controle_quadrado #(.H_ATIVO(H), .V_ATIVO(V), .PASSO(P)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pausa(pausa),
    .sw_tamanhos(sw_tamanhos), .sw_cor(sw_cor),
    .pos_x(pos_x), .pos_y(pos_y), .tamanho(tamanho), .cor(cor),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pos_x"}, pos_x, mx);
    chk({tag, ".pos_y"}, pos_y, my);
    chk({tag, ".tamanho"}, tamanho, mt);
    chk({tag, ".cor"}, cor, mc);
  endtask

  task automatic m_reset();
    mx = 0; my = 0; mt = 4; mc = 0; dx = 0; dy = 0;
  endtask

  task automatic m_load(input int st, input int sc);
    mt = 4 * st + 4;
    mc = sc;
    if (mx + mt > H) mx = H - mt;
    if (my + mt > V) my = V - mt;
  endtask

  task automatic m_step(input int lim, input int p_in, input int d_in,
                        output int p_out, output int d_out);
    p_out = p_in;
    d_out = d_in;
`ifdef REBATE_EN
    if (d_in == 0) begin
      if (p_in + mt + P >= lim) begin p_out = lim - mt; d_out = 1; end
      else p_out = p_in + P;
    end else begin
      if (p_in <= P) begin p_out = 0; d_out = 0; end
      else p_out = p_in - P;
    end
`else
    d_out = 0;
    if (p_in + mt + P > lim) p_out = 0;
    else p_out = p_in + P;
`endif
  endtask

  // Called at a negedge with vsync high for at least one prior posedge.
  task automatic do_frame(input int p, input int st, input int sc, input bit glitch, input bit junk);
    pausa = p[0]; sw_tamanhos = 6'(st); sw_cor = 4'(sc);
    vsync = 1'b0;
    @(negedge clk);
    chk("tick_c1", frame_tick, 1);
    chk_state("c1");
    if (glitch) vsync = 1'b1;
    m_load(st, sc);
    @(negedge clk);
    chk_state("c2");
    if (glitch) vsync = 1'b0;
    if (junk) begin
      pausa = 1'($urandom); sw_tamanhos = 6'($urandom); sw_cor = 4'($urandom);
    end
    if (p == 0) m_step(H, mx, dx, mx, dx);
    @(negedge clk);
    chk_state("c3");
    chk("tick_c3", frame_tick, glitch ? 1 : 0);
    if (p == 0) m_step(V, my, dy, my, dy);
    @(negedge clk);
    chk_state("c4");
    chk("tick_c4", frame_tick, 0);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    for (int i = 0; i < 10; i++) begin
      vsync = ~vsync;
      @(negedge clk);
      chk("reset_hold", {pos_x, pos_y, tamanho, cor, frame_tick},
          {10'd0, 10'd0, 10'd4, 4'd0, 1'b0});
    end
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,  0,   4,  0};
    tbl[1] = '{63, 15, 256, 15};
    tbl[2] = '{10, 3,  44,  3};
    tbl[3] = '{1,  6,   8,  6};
    tbl[4] = '{24, 10, 100, 10};

    reset = 1'b1; vsync = 1'b1; pausa = 1'b0; sw_tamanhos = '0; sw_cor = '0;
    m_reset();
    @(negedge clk);
    do_reset();

    // latch table, paused so the positions stay put
    for (int i = 0; i < 5; i++) begin
      do_frame(1, tbl[i].st, tbl[i].sc, 1'b0, 1'b0);
      chk("tbl_tam", tamanho, tbl[i].exp_tam);
      chk("tbl_cor", cor, tbl[i].exp_cor);
    end

    // switches changed between frames must not reach the outputs
    sw_tamanhos = 6'd5; sw_cor = 4'd1; pausa = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_tam", tamanho, 100);
    chk("hold_cor", cor, 10);
    do_frame(1, 5, 1, 1'b0, 1'b0);
    chk("next_tam", tamanho, 24);
    chk("next_cor", cor, 1);

    // motion from reset, then drive to the right edge
    do_reset();
    for (int i = 0; i < 10; i++) do_frame(0, 24, 10, 1'b0, 1'b0);
    chk("motion_x", pos_x, 20);
    chk("motion_y", pos_y, 20);
    for (int i = 0; i < 259; i++) do_frame(0, 24, 10, i == 5, 1'b0);
    chk("edge_x", pos_x, 538);
    do_frame(0, 24, 10, 1'b0, 1'b0);
    chk("edge_next_x", pos_x, 540);
    do_frame(0, 24, 10, 1'b0, 1'b0);
`ifdef REBATE_EN
    chk("bounce_x", pos_x, 538);
`else
    chk("wrap_x", pos_x, 0);
`endif

    // pause with clamp
    do_reset();
    for (int i = 0; i < 150; i++) do_frame(0, 24, 10, 1'b0, 1'b0);
    chk("pre_pause_y", pos_y, 300);
    for (int k = 0; k < 3; k++) begin
      do_frame(1, 63, 7, 1'b0, 1'b0);
      chk("pause_tam", tamanho, 256);
      chk("pause_y", pos_y, 224);
      chk("pause_x", pos_x, 300);
    end

    // reset asserted while in MOVE_X
    pausa = 1'b0; sw_tamanhos = 6'd10; sw_cor = 4'd5; vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid", {pos_x, pos_y, tamanho, cor, frame_tick},
        {10'd0, 10'd0, 10'd4, 4'd0, 1'b0});
    m_reset();
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_frame(0, 24, 10, 1'b0, 1'b0);

    // random frames against the model
    do_reset();
    for (int i = 0; i < 80; i++)
      do_frame(($urandom_range(3) == 0) ? 1 : 0, int'($urandom_range(63)),
               int'($urandom_range(15)), $urandom_range(7) == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
